// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit. An operation is accepted
//   from IDLE, then runs one radix-2 step per cycle for XLEN cycles in CALC.
//   Sign correction and result selection happen in FIN. Latency is the same
//   for all eight M-extension operations.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   request, sampled only in IDLE
//   flush     in   synchronous abort (wins over start, suppresses done)
//   funct3    in   3  operation select (MUL..REMU)
//   rs1       in   XLEN  operand A (multiplicand / dividend)
//   rs2       in   XLEN  operand B (multiplier / divisor)
//   rdadr_in  in   5  destination register index
//   busy      out  operation in flight
//   done      out  one-cycle result-valid pulse
//   regwrite  out  identical to done
//   rdadr     out  5  destination index captured at accept
//   result    out  XLEN  result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rdadr_in,
  output logic            busy,
  output logic            done,
  output logic            regwrite,
  output logic [4:0]      rdadr,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]     LAST_CNT = CW'(XLEN - 1);
  localparam logic [CW-1:0]     ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  // acc/lo form the 2*XLEN product for multiply, remainder/quotient for divide
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  // multiplicand magnitude for multiply, divisor magnitude for divide
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            div0_q, div0_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [4:0]      rdadr_q, rdadr_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept_s;
  logic            a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   rsh_s;
  logic [XLEN:0]   diff_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s;
  logic [XLEN-1:0] fin_result_s;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic signed_a(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100, 3'b110: signed_a = 1'b1;
      default:                        signed_a = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic signed_b(input logic [2:0] f);
    case (f)
      3'b001, 3'b100, 3'b110: signed_b = 1'b1;
      default:                signed_b = 1'b0;
    endcase
  endfunction

  // Conditional two's-complement negation at XLEN width
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    if (n) begin
      neg_if = ~v + ONE_X;
    end else begin
      neg_if = v;
    end
  endfunction

  assign accept_s = (state_q == IDLE) && start && !flush;

  assign a_neg_s = signed_a(funct3) & rs1[XLEN-1];
  assign b_neg_s = signed_b(funct3) & rs2[XLEN-1];
  assign a_mag_s = neg_if(rs1, a_neg_s);
  assign b_mag_s = neg_if(rs2, b_neg_s);

  // Multiply step: add multiplicand into upper half when the low bit is set
  assign sum_s  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  // Divide step: shift next dividend bit into the partial remainder and trial-subtract;
  // the partial remainder stays below the divisor, so bit XLEN of diff is the borrow
  assign rsh_s  = {acc_q, lo_q[XLEN-1]};
  assign diff_s = rsh_s - {1'b0, opnd_q};

  // Sign correction and result selection for FIN
  always_comb begin
    prod_s = {acc_q, lo_q};
    if (sign_a_q ^ sign_b_q) begin
      prod_fix_s = ~prod_s + ONE_2X;
    end else begin
      prod_fix_s = prod_s;
    end
    // divide by zero yields all ones regardless of dividend sign
    if (div0_q) begin
      quo_fix_s = {XLEN{1'b1}};
    end else begin
      quo_fix_s = neg_if(lo_q, sign_a_q ^ sign_b_q);
    end
    rem_fix_s = neg_if(acc_q, sign_a_q);
    case (op_q)
      3'b000:                 fin_result_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_result_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_result_s = quo_fix_s;
      3'b110, 3'b111:         fin_result_s = rem_fix_s;
      default:                fin_result_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (cnt_q == LAST_CNT) begin
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state: operand capture on accept, one iteration per CALC cycle
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    if (accept_s) begin
      cnt_d    = {CW{1'b0}};
      op_d     = funct3;
      acc_d    = {XLEN{1'b0}};
      sign_a_d = a_neg_s;
      sign_b_d = b_neg_s;
      div0_d   = (rs2 == {XLEN{1'b0}});
      if (funct3[2]) begin
        lo_d   = a_mag_s;
        opnd_d = b_mag_s;
      end else begin
        lo_d   = b_mag_s;
        opnd_d = a_mag_s;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + ONE_CNT;
      if (op_q[2]) begin
        if (!diff_s[XLEN]) begin
          acc_d = diff_s[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = rsh_s[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = sum_s[XLEN:1];
        lo_d  = {sum_s[0], lo_q[XLEN-1:1]};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'b000;
      acc_q    <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      opnd_q   <= {XLEN{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
    end
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    busy_d = (state_d != IDLE);
    if ((state_q == FIN) && !flush) begin
      done_d   = 1'b1;
      result_d = fin_result_s;
    end else begin
      done_d   = 1'b0;
      result_d = result_q;
    end
    if (accept_s) begin
      rdadr_d = rdadr_in;
    end else begin
      rdadr_d = rdadr_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdadr_q  <= 5'd0;
      result_q <= {XLEN{1'b0}};
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdadr_q  <= rdadr_d;
      result_q <= result_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign regwrite = done_q;
  assign rdadr    = rdadr_q;
  assign result   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit (XLEN=32). Expected values are
//   hand-computed constants; all comparisons go through check().
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rdadr_in;
  logic        busy;
  logic        done;
  logic        regwrite;
  logic [4:0]  rdadr;
  logic [31:0] result;

  int errs   = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .funct3   (funct3),
    .rs1      (rs1),
    .rs2      (rs2),
    .rdadr_in (rdadr_in),
    .busy     (busy),
    .done     (done),
    .regwrite (regwrite),
    .rdadr    (rdadr),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; operands are scrambled right after accept
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start    = 1'b1;
    funct3   = f3;
    rs1      = a;
    rs2      = b;
    rdadr_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
    rdadr_in = 5'd31;
  endtask

  // Wait for done, bounded; returns cycles waited and busy samples seen
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    int bc;
    issue(f3, a, b, rd);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, 32'd33);
    check({tag, " busy_cycles"}, bc, 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " rdadr"}, {27'd0, rdadr}, {27'd0, rd});
    check({tag, " regwrite"}, {31'd0, regwrite}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bc;
    int ndone;
    reset    = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'b000;
    rs1      = 32'd0;
    rs2      = 32'd0;
    rdadr_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset regwrite", {31'd0, regwrite}, 32'd0);
    check("reset rdadr", {27'd0, rdadr}, 32'd0);
    check("reset result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("MUL",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run_op("MULH",     3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
    run_op("MULHU",    3'b011, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000);
    run_op("MULHSU",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
    run_op("MULHU_m1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE);
    run_op("MULH_m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000000);
    run_op("DIV",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD);
    run_op("REM",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF);
    run_op("DIVU",     3'b101, 32'd100,      32'd7,        5'd13, 32'd14);
    run_op("REMU",     3'b111, 32'd100,      32'd7,        5'd0,  32'd2);
    run_op("DIVU_z",   3'b101, 32'd13,       32'd0,        5'd14, 32'hFFFFFFFF);
    run_op("REM_z",    3'b110, 32'd13,       32'd0,        5'd15, 32'd13);
    run_op("DIV_negz", 3'b100, 32'hFFFFFFF3, 32'd0,        5'd16, 32'hFFFFFFFF);
    run_op("REM_negz", 3'b110, 32'hFFFFFFF3, 32'd0,        5'd17, 32'hFFFFFFF3);
    run_op("DIV_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000);
    run_op("REM_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0);

    // start while busy is ignored; back-to-back accept right after done
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    funct3   = 3'b000;
    rs1      = 32'd2;
    rs2      = 32'd3;
    rdadr_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("busy_start latency", lat, 32'd28);
    check("busy_start result", result, 32'd14);
    check("busy_start rdadr", {27'd0, rdadr}, 32'd3);
    issue(3'b000, 32'd2, 32'd3, 5'd9);
    wait_done(lat, bc);
    check("b2b latency", lat, 32'd33);
    check("b2b result", result, 32'd6);
    check("b2b rdadr", {27'd0, rdadr}, 32'd9);
    @(posedge clk); #1;

    // flush with start in IDLE: not accepted
    start = 1'b1;
    flush = 1'b1;
    funct3 = 3'b000;
    rs1 = 32'd5;
    rs2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_idle busy", {31'd0, busy}, 32'd0);

    // flush at cycle 10 of CALC
    issue(3'b000, 32'd5, 32'd6, 5'd4);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd6);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("flush no_done", ndone, 32'd0);

    // async reset mid-CALC
    issue(3'b000, 32'd9, 32'd9, 5'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset busy", {31'd0, busy}, 32'd0);
    check("areset done", {31'd0, done}, 32'd0);
    check("areset regwrite", {31'd0, regwrite}, 32'd0);
    check("areset rdadr", {27'd0, rdadr}, 32'd0);
    check("areset result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("areset no_done", ndone, 32'd0);

    run_op("MUL_after", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
- Consumes the registered rs1/rs2 operands and returns a 32-bit result with rdadr/regwrite for the writeback path into the register file.
- Fixed latency for all eight M-extension operations; the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; power of two, minimum 8. Iteration counter width is clog2(XLEN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort of any in-flight or requested operation.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (dividend / multiplicand).
- rs2  input  XLEN  operand B (divisor / multiplier).
- rdadr_in  input  5  destination register index.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse; result valid.
- regwrite  output  1  identical to done.
- rdadr  output  5  destination index captured at start.
- result  output  XLEN  result; held until the next done.

Behaviour:
- Reset: asynchronous. State goes to IDLE; busy, done, regwrite = 0; result = 0; rdadr = 0; the in-flight operation is discarded with no done. Reset mid-operation never produces done.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - On start=1 and flush=0 at edge E0: latch funct3 and rdadr_in.
  - Latch |rs1| and |rs2|, plus sign flags for the signed operand(s): MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; MUL and unsigned ops none.
  - Clear the counter; go to CALC.
- CALC: one radix-2 step per cycle for XLEN cycles (edges E0+1..E0+XLEN).
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing an XLEN quotient and remainder.
  - At the last step go to FIN.
- FIN at edge E0+XLEN+1:
  - Apply sign correction:
    - product negated if sign flags differ;
    - quotient negated if dividend sign differs from divisor sign;
    - remainder takes the dividend sign.
  - Select the result:
    - MUL returns the low XLEN bits;
    - MULH/MULHSU/MULHU return the high XLEN bits;
    - DIV/DIVU return the quotient;
    - REM/REMU return the remainder.
  - Register result; done and regwrite = 1 for exactly that one cycle; go to IDLE.
- Latency: done is high during the cycle following edge E0+33 (XLEN=32). busy is high from after E0 until edge E0+33. Earliest next accept is edge E0+34.
- Divide by zero (rs2 = 0): DIV/DIVU quotient = all ones; REM/REMU = rs1 unchanged. Same latency, no exception.
- Signed overflow (DIV rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000, REM = 0.
- start while busy is ignored; no queueing. Operands are consumed only at the accept edge, so later changes to rs1/rs2 have no effect.
- flush=1 at any edge: state goes to IDLE, no done/regwrite, result keeps its previous value. flush with start in IDLE: flush wins, not accepted. flush in FIN: done is suppressed.
- rdadr = 0 still asserts regwrite; the register file discards writes to x0.
- Outputs change only on clock edges or reset; no combinational input-to-output paths.

Test Plan:
- Reset, then MUL rs1=7, rs2=0xFFFFFFFD (-3) -> busy high 33 cycles; done one cycle with result 0xFFFFFFEB; rdadr = captured index; regwrite = done.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Corner cases: DIVU 13/0 -> 0xFFFFFFFF; REM 13/0 -> 13; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-to-back and start-while-busy: start again 5 cycles after accept with different operands -> ignored, first result only. New start at E0+34 -> accepted; second done 34 cycles later.
- Flush at cycle 10 of CALC -> no done, busy low next cycle, result unchanged. Async reset asserted mid-CALC -> all outputs 0 immediately; no done after release.
